// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_CMD   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_ADD  = 3'd3,
        ST_READ_DATA = 3'd4
    } spi_state_e;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned TX_BITS    = 8;

endpackage

// File: rtl/spi_tx_serializer.sv
// Loads one read-data word on tx_valid and shifts it out MSB first, then idles at 0.
module spi_tx_serializer
    import spi_pkg::*;
#(
    parameter int unsigned W = TX_BITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         load_en_i,
    input  logic         tx_valid_i,
    input  logic [W-1:0] tx_data_i,
    output logic         miso_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    logic [W-1:0]     sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             miso_q, miso_d;

    // cnt_q counts bits already on the line; MISO drops to 0 one edge after the last bit
    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = done_q;
        miso_d = miso_q;
        if (clear_i) begin
            sh_d   = '0;
            cnt_d  = '0;
            busy_d = 1'b0;
            done_d = 1'b0;
            miso_d = 1'b0;
        end else if (busy_q) begin
            if (cnt_q == CNT_W'(W)) begin
                miso_d = 1'b0;
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                miso_d = sh_q[W-1];
                sh_d   = {sh_q[W-2:0], 1'b0};
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end else if (load_en_i && tx_valid_i) begin
            miso_d = tx_data_i[W-1];
            sh_d   = {tx_data_i[W-2:0], 1'b0};
            cnt_d  = CNT_W'(1);
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            miso_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            miso_q <= miso_d;
        end
    end

    assign miso_o = miso_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: deserialises MOSI command frames for the RAM and returns read data on MISO.
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [ADDR_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [ADDR_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int unsigned FRAME_W = ADDR_W + 2;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

    spi_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FRAME_W-2:0]  shift_q, shift_d;
    logic [FRAME_W-1:0]  rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rd_addr_seen_q, rd_addr_seen_d;

    logic                tx_load_en;
    logic                tx_busy;
    logic                tx_done;

    // cnt_q == FRAME_W marks a completed frame; further MOSI bits are dropped until SS_n rises
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_seen_d = rd_addr_seen_q;
        if (SS_n) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_CHK_CMD;
                    cnt_d   = '0;
                end
                ST_CHK_CMD: begin
                    cnt_d = '0;
                    if (!MOSI)              state_d = ST_WRITE;
                    else if (rd_addr_seen_q) state_d = ST_READ_DATA;
                    else                     state_d = ST_READ_ADD;
                end
                ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                    if (cnt_q != CNT_W'(FRAME_W)) begin
                        shift_d = {shift_q[FRAME_W-3:0], MOSI};
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                            rx_data_d  = {shift_q, MOSI};
                            rx_valid_d = 1'b1;
                            if (state_q == ST_READ_ADD)  rd_addr_seen_d = 1'b1;
                            if (state_q == ST_READ_DATA) rd_addr_seen_d = 1'b0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_seen_q <= rd_addr_seen_d;
        end
    end

    // Read data is accepted only once, after the read-data frame has been strobed out
    assign tx_load_en = (state_q == ST_READ_DATA) && (cnt_q == CNT_W'(FRAME_W)) && !tx_busy && !tx_done;

    spi_tx_serializer #(
        .W(ADDR_W)
    ) u_tx (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (SS_n),
        .load_en_i  (tx_load_en),
        .tx_valid_i (tx_valid),
        .tx_data_i  (tx_data),
        .miso_o     (MISO),
        .busy_o     (tx_busy),
        .done_o     (tx_done)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench for spi_slave_ctrl against a frame-level reference model.
module tb_spi_slave_ctrl;
    import spi_pkg::*;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned FRAME_W = ADDR_W + 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [ADDR_W-1:0]  tx_data;
    logic               tx_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: pending-read-address flag and last delivered command word
    bit                 model_seen = 1'b0;
    logic [FRAME_W-1:0] model_rx   = '0;

    always #5 clk = ~clk;

    spi_slave_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame; abort_at = index of payload bit at whose edge SS_n rises (-1 for none)
    task automatic do_frame(input bit cmd, input logic [FRAME_W-1:0] payload, input int abort_at,
                            input bit keep_ss, input bit do_tx, input logic [ADDR_W-1:0] txv,
                            input string tag);
        bit         is_rd_data;
        spi_state_e exp_st;
        logic [FRAME_W-1:0] held;
        held       = model_rx;
        is_rd_data = cmd && model_seen;
        exp_st     = !cmd ? ST_WRITE : (model_seen ? ST_READ_DATA : ST_READ_ADD);

        SS_n = 1'b0; MOSI = 1'($urandom_range(0, 1));
        tx_valid = 1'($urandom_range(0, 1)); tx_data = ADDR_W'($urandom);
        step();
        MOSI = cmd;
        step();
        n_tests++;
        if (dut.state_q !== exp_st) begin
            n_fail++;
            $display("FAIL %s route: got state %0d want %0d", tag, dut.state_q, exp_st);
        end
        for (int j = 0; j < int'(FRAME_W); j++) begin
            MOSI     = payload[FRAME_W-1-j];
            tx_valid = 1'($urandom_range(0, 1));
            tx_data  = ADDR_W'($urandom);
            if (j == abort_at) SS_n = 1'b1;
            step();
            n_tests++;
            if (j == abort_at) begin
                if (rx_valid !== 1'b0 || MISO !== 1'b0 || dut.state_q !== ST_IDLE || rx_data !== held
                    || dut.rd_addr_seen_q !== model_seen) begin
                    n_fail++;
                    $display("FAIL %s abort@%0d: rx_valid=%b MISO=%b state=%0d rx_data=%h seen=%b want 0 0 0 %h %b",
                             tag, j, rx_valid, MISO, dut.state_q, rx_data, dut.rd_addr_seen_q, held, model_seen);
                end
                tx_valid = 1'b0;
                return;
            end
            if (j == int'(FRAME_W) - 1) begin
                if (rx_valid !== 1'b1 || rx_data !== payload) begin
                    n_fail++;
                    $display("FAIL %s strobe: rx_valid=%b rx_data=%h want 1 %h", tag, rx_valid, rx_data, payload);
                end
            end else if (rx_valid !== 1'b0 || MISO !== 1'b0 || rx_data !== held) begin
                n_fail++;
                $display("FAIL %s bit%0d: rx_valid=%b MISO=%b rx_data=%h want 0 0 %h",
                         tag, j, rx_valid, MISO, rx_data, held);
            end
        end

        model_rx = payload;
        if (cmd && !model_seen) model_seen = 1'b1;
        else if (cmd)           model_seen = 1'b0;
        n_tests++;
        if (dut.rd_addr_seen_q !== model_seen) begin
            n_fail++;
            $display("FAIL %s flag: got %b want %b", tag, dut.rd_addr_seen_q, model_seen);
        end

        // trailing MOSI bits are ignored; tx_valid is ignored outside the read-data wait
        for (int j = 0; j < 2; j++) begin
            MOSI     = 1'($urandom_range(0, 1));
            tx_valid = is_rd_data ? 1'b0 : 1'b1;
            tx_data  = ADDR_W'($urandom);
            step();
            n_tests++;
            if (rx_valid !== 1'b0 || rx_data !== payload || MISO !== 1'b0) begin
                n_fail++;
                $display("FAIL %s trail%0d: rx_valid=%b rx_data=%h MISO=%b want 0 %h 0",
                         tag, j, rx_valid, rx_data, MISO, payload);
            end
        end
        tx_valid = 1'b0;

        if (is_rd_data && do_tx) begin
            tx_valid = 1'b1; tx_data = txv;
            step();
            for (int b = ADDR_W - 1; b >= 0; b--) begin
                if (b != int'(ADDR_W) - 1) begin
                    tx_valid = 1'($urandom_range(0, 1));
                    tx_data  = ADDR_W'($urandom);
                    step();
                end
                n_tests++;
                if (MISO !== txv[b]) begin
                    n_fail++;
                    $display("FAIL %s miso bit%0d: got %b want %b", tag, b, MISO, txv[b]);
                end
            end
            for (int j = 0; j < 3; j++) begin
                tx_valid = 1'b1; tx_data = ADDR_W'($urandom);
                step();
                n_tests++;
                if (MISO !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s miso tail%0d: got %b want 0", tag, j, MISO);
                end
            end
            tx_valid = 1'b0;
        end

        if (!keep_ss) begin
            SS_n = 1'b1;
            step();
            n_tests++;
            if (MISO !== 1'b0 || rx_valid !== 1'b0 || dut.state_q !== ST_IDLE) begin
                n_fail++;
                $display("FAIL %s end: MISO=%b rx_valid=%b state=%0d want 0 0 0", tag, MISO, rx_valid, dut.state_q);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
        step(); step();
        n_tests++;
        if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== '0 || dut.state_q !== ST_IDLE
            || dut.rd_addr_seen_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: MISO=%b rx_valid=%b rx_data=%h state=%0d seen=%b want all 0",
                     MISO, rx_valid, rx_data, dut.state_q, dut.rd_addr_seen_q);
        end
        rst = 1'b0;
        step();
        model_seen = 1'b0; model_rx = '0;
    endtask

    task automatic test_write_frame();
        do_frame(1'b0, 10'h0A5, -1, 1'b0, 1'b0, '0, "wr_addr");
    endtask

    task automatic test_read_pair();
        do_frame(1'b1, 10'h203, -1, 1'b0, 1'b0, '0, "rd_addr");
        do_frame(1'b1, 10'h300, -1, 1'b0, 1'b1, 8'hC3, "rd_data");
    endtask

    task automatic test_abort();
        do_frame(1'b0, 10'h1F0, 6, 1'b0, 1'b0, '0, "abort6");
        do_frame(1'b0, 10'h15A, -1, 1'b0, 1'b0, '0, "after_abort");
        do_frame(1'b0, 10'h0FF, 9, 1'b0, 1'b0, '0, "abort_last");
        // aborted read-data frame keeps the pending address
        do_frame(1'b1, 10'h211, -1, 1'b0, 1'b0, '0, "ab_rd_addr");
        do_frame(1'b1, 10'h3AA, 4, 1'b0, 1'b0, '0, "ab_rd_data");
        do_frame(1'b1, 10'h3AB, -1, 1'b1, 1'b0, '0, "rd_data_keep");
        tx_valid = 1'b1; tx_data = 8'hFF;
        step();
        tx_valid = 1'b0;
        step();
        SS_n = 1'b1;
        step();
        n_tests++;
        if (MISO !== 1'b0 || dut.state_q !== ST_IDLE) begin
            n_fail++;
            $display("FAIL tx_abort: MISO=%b state=%0d want 0 0", MISO, dut.state_q);
        end
    endtask

    task automatic test_flag_persistence();
        if (model_seen) do_frame(1'b1, 10'h300, -1, 1'b0, 1'b0, '0, "fp_norm");
        do_frame(1'b1, 10'h240, -1, 1'b0, 1'b0, '0, "fp_rd_addr");
        do_frame(1'b0, 10'h155, -1, 1'b0, 1'b0, '0, "fp_write");
        do_frame(1'b1, 10'h300, -1, 1'b0, 1'b1, 8'h5A, "fp_rd_data");
    endtask

    task automatic test_async_reset();
        do_frame(1'b1, 10'h2C0, -1, 1'b0, 1'b0, '0, "ar_rd_addr");
        do_frame(1'b1, 10'h3C0, -1, 1'b1, 1'b0, '0, "ar_rd_data");
        tx_valid = 1'b1; tx_data = 8'hE7;
        step();
        tx_valid = 1'b0;
        step(); step();
        n_tests++;
        if (MISO !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_pre: MISO=%b want 1", MISO);
        end
        #2 rst = 1'b1;
        #1;
        model_seen = 1'b0; model_rx = '0;
        n_tests++;
        if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== '0 || dut.rd_addr_seen_q !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_mid_tx: MISO=%b rx_valid=%b rx_data=%h seen=%b want 0 0 0 0",
                     MISO, rx_valid, rx_data, dut.rd_addr_seen_q);
        end
        SS_n = 1'b1;
        step();
        rst = 1'b0;
        step();
        // reset while an address is pending clears it
        do_frame(1'b1, 10'h201, -1, 1'b0, 1'b0, '0, "ar_rd_addr2");
        #3 rst = 1'b1;
        #1;
        model_seen = 1'b0; model_rx = '0;
        n_tests++;
        if (dut.rd_addr_seen_q !== 1'b0 || rx_data !== '0) begin
            n_fail++;
            $display("FAIL ar_flag: seen=%b rx_data=%h want 0 0", dut.rd_addr_seen_q, rx_data);
        end
        step();
        rst = 1'b0;
        do_frame(1'b1, 10'h2FE, -1, 1'b0, 1'b1, 8'h81, "ar_next_read");
    endtask

    task automatic test_back_to_back();
        do_frame(1'b0, 10'h012, -1, 1'b0, 1'b0, '0, "b2b_wa");
        do_frame(1'b0, 10'h134, -1, 1'b0, 1'b0, '0, "b2b_wd");
        do_frame(1'b1, 10'h256, -1, 1'b0, 1'b0, '0, "b2b_ra");
        do_frame(1'b1, 10'h378, -1, 1'b0, 1'b1, 8'h96, "b2b_rd");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            bit                 cmd;
            logic [FRAME_W-1:0] pl;
            int                 ab;
            cmd = 1'($urandom_range(0, 1));
            pl  = {cmd, (FRAME_W-1)'($urandom)};
            ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, FRAME_W - 1)) : -1;
            do_frame(cmd, pl, ab, 1'b0, 1'b1, ADDR_W'($urandom), "rand");
            if (ab >= 0 || $urandom_range(0, 1) == 1) step();
        end
    endtask

    initial begin
        test_reset();
        test_write_frame();
        test_read_pair();
        test_abort();
        test_flag_persistence();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

SPI slave front end that sits directly upstream of the single-port RAM. It deserialises MOSI frames into the 10-bit RAM command word `rx_data` with a one-cycle `rx_valid` strobe. For read-data frames, it captures the RAM's `tx_data` on `tx_valid` and serialises it back on MISO. All SPI lines are sampled on the system clock; there is no separate SCK domain.

## Interface
Parameters:
- `ADDR_W`, 8: payload width; `rx_data` is `ADDR_W+2` bits, and `tx_data` is `ADDR_W` bits.

Ports:
- `clk`, in, 1: system clock; all logic on rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `SS_n`, in, 1: slave select, active low; high aborts any frame.
- `MOSI`, in, 1: serial data in, MSB first.
- `MISO`, out, 1: serial data out, MSB first.
- `rx_data`, out, 10: command word to RAM; bits [9:8] are the opcode, bits [7:0] are address/data.
- `rx_valid`, out, 1: one-cycle strobe qualifying `rx_data`.
- `tx_data`, in, 8: read data from RAM.
- `tx_valid`, in, 1: qualifies `tx_data`.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- Internal flag `rd_addr_seen` tracks whether a read address is pending; it resets to 0.
- Frame format: 1 command bit, then 10 payload bits (MSB first). Payload bit 9 normally repeats the command bit. The payload is forwarded unchecked; only the command bit steers the FSM.
- Transitions (any state goes to IDLE when SS_n=1):
  - IDLE → CHK_CMD when SS_n=0.
  - CHK_CMD, MOSI=0 → WRITE.
  - CHK_CMD, MOSI=1 and !rd_addr_seen → READ_ADD.
  - CHK_CMD, MOSI=1 and rd_addr_seen → READ_DATA.
- WRITE/READ_ADD/READ_DATA shift 10 MOSI bits into the receive register via a 4-bit counter. When the 10th bit is captured, `rx_valid` pulses and `rx_data` updates.
- Flag updates:
  - READ_ADD completion sets `rd_addr_seen`.
  - READ_DATA completion clears `rd_addr_seen`.
  - WRITE completion leaves it unchanged.
- READ_DATA transmit, after its `rx_valid`:
  - Wait for `tx_valid`=1, then latch `tx_data` into the transmit shifter.
  - Drive 8 bits on MISO, bit 7 first.
  - After the 8th bit, MISO returns to 0 and the FSM holds in READ_DATA until SS_n=1.
- Extra MOSI bits after a completed frame are ignored until SS_n=1.
- `tx_valid` outside the READ_DATA wait phase is ignored.

## Timing
- Reset values: MISO=0, `rx_valid`=0, `rx_data`=0, state IDLE, `rd_addr_seen`=0, counters 0.
- Frame receive, with edge k sampling SS_n=0 in IDLE:
  - Edge k+1 samples the command bit.
  - Edges k+2..k+11 sample payload bits 9..0.
  - `rx_valid`=1 for exactly the cycle after edge k+11, with `rx_data` stable; `rx_data` holds its value afterwards.
- Transmit, with edge t sampling `tx_valid`=1:
  - MISO = tx_data[7] after edge t, then bits [6..0] after edges t+1..t+7.
  - MISO=0 after edge t+8.
- Abort: SS_n=1 sampled at any edge:
  - Next state is IDLE and counters clear.
  - No `rx_valid` for a partial frame; MISO=0 from the next cycle.
  - `rd_addr_seen` is unchanged, except that an aborted READ_DATA frame does not clear it.
- If SS_n=1 and the 10th payload bit coincide at the same edge, abort wins: no strobe.
- `rst` mid-frame: outputs return to reset values immediately (asynchronous); the frame is lost.
- `rx_valid` is never asserted on two consecutive cycles.

## Structure
- Shared package `spi_pkg`:
  - state enum `spi_state_e`.
  - opcode constants `OP_WR_ADDR`=2'b00, `OP_WR_DATA`=2'b01, `OP_RD_ADDR`=2'b10, `OP_RD_DATA`=2'b11.
  - `FRAME_BITS`=10, `TX_BITS`=8.
- One sub-module, `spi_tx_serializer`: load on `tx_valid`, 8-bit MSB-first shift, done flag. The FSM, receive shifter and flag stay in the top module.

## Test plan
- Write-address frame: SS_n low, then MOSI 0 followed by 00_1010_0101 → single `rx_valid` with `rx_data`=10'h0A5, 11 edges after SS_n sampled low; MISO stays 0.
- Read pair: read-address frame 1 + 10_0000_0011 → `rx_data`=10'h203 and `rd_addr_seen`=1. SS_n high, then read-data frame 1 + 11_0000_0000 → `rx_data`=10'h300. Then `tx_valid` with `tx_data`=8'hC3 → MISO sequence 1,1,0,0,0,0,1,1, then 0.
- Abort: SS_n rises after 6 payload bits → no `rx_valid`, state IDLE; the next full frame is received correctly.
- Flag persistence: read-address frame, then write frame, then read frame → the read frame routes to READ_DATA.
- Async reset asserted mid-transmit (after 3 MISO bits) → MISO=0, `rx_valid`=0, `rd_addr_seen`=0 immediately; the next read frame routes to READ_ADD.
